// File: rtl/diff_filter_p.sv
// Derivative stage: first difference or 5-point kernel on accepted samples, saturated to DW bits.
// Latency: 1 cycle from accepting edge to dout/out_valid/sat; one sample per cycle.
// No backpressure: every in_valid sample is accepted; output suppressed during warm-up/mode change.
module diff_filter_p #(
    parameter int DW        = 16,
    parameter bit SIGNED_IN = 1'b0,
    parameter int SHIFT     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          in_valid,
    input  logic          mode,
    output logic [DW-1:0] dout,
    output logic          out_valid,
    output logic          sat
);

    // Four guard bits hold the 5-point kernel sum (about +/-3*2^DW) without overflow.
    localparam int EW = DW + 4;
    localparam logic signed [EW-1:0] MAXV = EW'((2 ** (DW - 1)) - 1);
    localparam logic signed [EW-1:0] MINV = ~MAXV;

    logic signed [EW-1:0] x;
    logic signed [EW-1:0] x1_q, x2_q, x3_q, x4_q;
    logic signed [EW-1:0] x1_d, x2_d, x3_d, x4_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [DW-1:0]        dout_q, dout_d;
    logic                 vld_q, vld_d;
    logic                 sat_q, sat_d;

    logic signed [EW-1:0] diff1;
    logic signed [EW-1:0] sum5;
    logic signed [EW-1:0] k5;
    logic signed [EW-1:0] y;
    logic                 emit;

    // Widen the incoming sample by zero- or sign-extension.
    always_comb begin
        if (SIGNED_IN) begin
            x = {{4{din[DW-1]}}, din};
        end else begin
            x = {4'b0000, din};
        end
    end

    // Both derivative candidates, then pick by the sample's mode.
    always_comb begin
        diff1 = x - x1_q;
        sum5  = (x <<< 1) + x1_q - x3_q - (x4_q <<< 1);
        k5    = sum5 >>> SHIFT;
        y     = mode ? k5 : diff1;
    end

    // Next state: history shift, warm-up/mode tracking, and saturated output capture.
    always_comb begin
        x1_d   = x1_q;
        x2_d   = x2_q;
        x3_d   = x3_q;
        x4_d   = x4_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        dout_d = dout_q;
        sat_d  = sat_q;
        vld_d  = 1'b0;
        emit   = 1'b0;
        if (in_valid) begin
            x4_d = x3_q;
            x3_d = x2_q;
            x2_d = x1_q;
            x1_d = x;
            if (mode != mode_q) begin
                // New mode restarts warm-up; this sample already counts as the first.
                mode_d = mode;
                cnt_d  = 3'd1;
            end else begin
                emit = mode_q ? (cnt_q >= 3'd4) : (cnt_q >= 3'd1);
                if (cnt_q < 3'd4) begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
        end
        if (emit) begin
            vld_d = 1'b1;
            if (y > MAXV) begin
                dout_d = MAXV[DW-1:0];
                sat_d  = 1'b1;
            end else if (y < MINV) begin
                dout_d = MINV[DW-1:0];
                sat_d  = 1'b1;
            end else begin
                dout_d = y[DW-1:0];
                sat_d  = 1'b0;
            end
        end
    end

    // State registers with synchronous reset that overrides any sample on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q   <= '0;
            x2_q   <= '0;
            x3_q   <= '0;
            x4_q   <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            x1_q   <= x1_d;
            x2_q   <= x2_d;
            x3_q   <= x3_d;
            x4_q   <= x4_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            sat_q  <= sat_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = vld_q;
    assign sat       = sat_q;

endmodule
